// File: rtl/card_shoe_dealer.sv
// rtl/card_shoe_dealer.sv - card shoe that deals ranks without replacement
module card_shoe_dealer #(
  parameter int CARD_MIN    = 1,
  parameter int CARD_MAX    = 10,
  parameter int RANK_COPIES = 4,
  parameter int TOP_COPIES  = 16,
  parameter int WIDTH       = 5,
  parameter int TOTAL       = (CARD_MAX - CARD_MIN) * RANK_COPIES + TOP_COPIES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       draw_req,
  input  logic                       shuffle,
  output logic [WIDTH-1:0]           card,
  output logic                       card_valid,
  output logic                       busy,
  output logic                       deck_empty,
  output logic [$clog2(TOTAL+1)-1:0] cards_left,
  output logic [WIDTH-1:0]           roll
);

  localparam int CL_W       = $clog2(TOTAL + 1);
  localparam int MAX_COPIES = (RANK_COPIES > TOP_COPIES) ? RANK_COPIES : TOP_COPIES;
  localparam int CNT_W      = $clog2(MAX_COPIES + 1);
  // Table spans the full index range of a WIDTH-bit rank so any cand value
  // addresses a real entry; ranks outside CARD_MIN..CARD_MAX stay at zero.
  localparam int DEPTH      = 1 << WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DEAL   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] count [0:DEPTH-1];

  // Number of copies of rank r in a freshly filled shoe.
  function automatic logic [CNT_W-1:0] full_count(input int r);
    if (r == CARD_MAX)
      return CNT_W'(TOP_COPIES);
    else if (r >= CARD_MIN && r < CARD_MAX)
      return CNT_W'(RANK_COPIES);
    else
      return '0;
  endfunction

  // Next rank in dealing order, CARD_MAX wraps back to CARD_MIN.
  function automatic logic [WIDTH-1:0] next_rank(input logic [WIDTH-1:0] r);
    if (r == WIDTH'(CARD_MAX))
      return WIDTH'(CARD_MIN);
    else
      return r + WIDTH'(1);
  endfunction

  assign deck_empty = (cards_left == '0);

  // Free-running start-point counter, independent of the dealing FSM.
  always_ff @(posedge clock) begin
    if (reset)
      roll <= WIDTH'(CARD_MIN);
    else if (enable)
      roll <= next_rank(roll);
  end

  // Dealing FSM with rank table; shuffle refills and aborts any draw in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= WIDTH'(CARD_MIN);
      card       <= '0;
      card_valid <= 1'b0;
      busy       <= 1'b0;
      cards_left <= CL_W'(TOTAL);
      for (int i = 0; i < DEPTH; i++)
        count[i] <= full_count(i);
    end else if (shuffle) begin
      state      <= IDLE;
      card_valid <= 1'b0;
      busy       <= 1'b0;
      cards_left <= CL_W'(TOTAL);
      for (int i = 0; i < DEPTH; i++)
        count[i] <= full_count(i);
    end else begin
      card_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Requests against an empty shoe are dropped without a pulse.
          if (draw_req && !deck_empty) begin
            cand  <= roll;
            state <= SEARCH;
            busy  <= 1'b1;
          end
        end
        SEARCH: begin
          // One probe per cycle; terminates since the shoe was non-empty at accept.
          if (count[cand] != '0) begin
            count[cand] <= count[cand] - CNT_W'(1);
            cards_left  <= cards_left - CL_W'(1);
            card        <= cand;
            card_valid  <= 1'b1;
            state       <= DEAL;
          end else begin
            cand <= next_rank(cand);
          end
        end
        DEAL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe_dealer.sv
// tb/tb_card_shoe_dealer.sv - directed self-checking bench for card_shoe_dealer
module tb_card_shoe_dealer;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       draw_req;
  logic       shuffle;
  logic [4:0] card;
  logic       card_valid;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;
  logic [4:0] roll;

  int checks;
  int passes;
  int hist [0:15];

  card_shoe_dealer dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .draw_req   (draw_req),
    .shuffle    (shuffle),
    .card       (card),
    .card_valid (card_valid),
    .busy       (busy),
    .deck_empty (deck_empty),
    .cards_left (cards_left),
    .roll       (roll)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_roll(input logic [4:0] target);
    int n;
    n = 0;
    while (roll !== target && n < 20) begin
      tick();
      n++;
    end
    if (roll !== target) begin
      checks++;
      $display("FAIL wait_roll: roll=%0d required=%0d", roll, target);
    end
  endtask

  // Pulse draw_req for one cycle; lat counts clocks from the accepting edge.
  task automatic do_draw(output logic [4:0] c, output int lat);
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    lat = 1;
    while (card_valid !== 1'b1 && lat < 14) begin
      tick();
      lat++;
    end
    c = card;
    if (card_valid === 1'b1) tick();
  endtask

  task automatic test_reset();
    logic [4:0] e;
    reset = 1'b1; enable = 1'b1; draw_req = 1'b0; shuffle = 1'b0;
    tick(); tick();
    checks++;
    if (roll !== 5'd1 || cards_left !== 6'd52 || deck_empty !== 1'b0 || busy !== 1'b0 ||
        card !== 5'd0 || card_valid !== 1'b0)
      $display("FAIL reset_state: roll=%0d left=%0d empty=%b busy=%b card=%0d valid=%b required 1 52 0 0 0 0",
               roll, cards_left, deck_empty, busy, card, card_valid);
    else passes++;
    reset = 1'b0;
    e = 5'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = (e == 5'd10) ? 5'd1 : e + 5'd1;
      checks++;
      if (roll !== e) $display("FAIL roll_seq step %0d: roll=%0d required=%0d", i, roll, e);
      else passes++;
    end
  endtask

  task automatic test_single_draw();
    logic [4:0] c;
    int lat;
    wait_roll(5'd3);
    do_draw(c, lat);
    hist[c]++;
    checks++;
    if (c !== 5'd3 || lat != 2 || cards_left !== 6'd51)
      $display("FAIL single_draw: card=%0d lat=%0d left=%0d required 3 2 51", c, lat, cards_left);
    else passes++;
  endtask

  task automatic test_exhausted_skip();
    logic [4:0] c;
    int lat;
    for (int i = 0; i < 3; i++) begin
      wait_roll(5'd3);
      do_draw(c, lat);
      hist[c]++;
      checks++;
      if (c !== 5'd3 || lat != 2)
        $display("FAIL drain_rank3 %0d: card=%0d lat=%0d required 3 2", i, c, lat);
      else passes++;
    end
    wait_roll(5'd3);
    do_draw(c, lat);
    hist[c]++;
    checks++;
    if (c !== 5'd4 || lat != 3 || cards_left !== 6'd47)
      $display("FAIL skip_rank3: card=%0d lat=%0d left=%0d required 4 3 47", c, lat, cards_left);
    else passes++;
  endtask

  task automatic test_drain_shoe();
    logic [4:0] c;
    int lat;
    int bad;
    int saw_valid;
    bad = 0;
    for (int i = 0; i < 47; i++) begin
      do_draw(c, lat);
      if (lat > 11 || c < 5'd1 || c > 5'd10) bad++;
      else hist[c]++;
    end
    checks++;
    if (bad != 0) $display("FAIL drain_latency: bad_draws=%0d required=0", bad);
    else passes++;
    for (int r = 1; r <= 10; r++) begin
      checks++;
      if (hist[r] != ((r == 10) ? 16 : 4))
        $display("FAIL rank_total %0d: dealt=%0d required=%0d", r, hist[r], (r == 10) ? 16 : 4);
      else passes++;
    end
    checks++;
    if (deck_empty !== 1'b1 || cards_left !== 6'd0)
      $display("FAIL deck_empty: empty=%b left=%0d required 1 0", deck_empty, cards_left);
    else passes++;
    draw_req = 1'b1;
    saw_valid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (card_valid === 1'b1 || busy === 1'b1) saw_valid++;
    end
    draw_req = 1'b0;
    checks++;
    if (saw_valid != 0) $display("FAIL empty_draw: active_cycles=%0d required=0", saw_valid);
    else passes++;
  endtask

  task automatic test_shuffle();
    logic [4:0] c;
    int lat;
    int saw_valid;
    shuffle = 1'b1; draw_req = 1'b1;
    tick();
    shuffle = 1'b0; draw_req = 1'b0;
    checks++;
    if (cards_left !== 6'd52 || deck_empty !== 1'b0 || busy !== 1'b0)
      $display("FAIL shuffle_refill: left=%0d empty=%b busy=%b required 52 0 0", cards_left, deck_empty, busy);
    else passes++;
    shuffle = 1'b1; draw_req = 1'b1;
    tick();
    shuffle = 1'b0; draw_req = 1'b0;
    checks++;
    if (cards_left !== 6'd52 || busy !== 1'b0)
      $display("FAIL shuffle_over_draw: left=%0d busy=%b required 52 0", cards_left, busy);
    else passes++;
    wait_roll(5'd5);
    do_draw(c, lat);
    checks++;
    if (c !== 5'd5 || lat != 2 || cards_left !== 6'd51)
      $display("FAIL post_shuffle_draw: card=%0d lat=%0d left=%0d required 5 2 51", c, lat, cards_left);
    else passes++;
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL search_entry: busy=%b required 1", busy);
    else passes++;
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    checks++;
    if (busy !== 1'b0 || cards_left !== 6'd52 || card !== 5'd5 || card_valid !== 1'b0)
      $display("FAIL shuffle_abort: busy=%b left=%0d card=%0d valid=%b required 0 52 5 0",
               busy, cards_left, card, card_valid);
    else passes++;
    saw_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (card_valid === 1'b1) saw_valid++;
    end
    checks++;
    if (saw_valid != 0) $display("FAIL abort_no_valid: pulses=%0d required=0", saw_valid);
    else passes++;
  endtask

  task automatic test_enable_and_reset();
    wait_roll(5'd7);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (roll !== 5'd7) $display("FAIL roll_frozen: roll=%0d required=7", roll);
    else passes++;
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || cards_left !== 6'd52 || roll !== 5'd1 || card !== 5'd0 || card_valid !== 1'b0)
      $display("FAIL reset_mid_search: busy=%b left=%0d roll=%0d card=%0d valid=%b required 0 52 1 0 0",
               busy, cards_left, roll, card, card_valid);
    else passes++;
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (roll !== 5'd1) $display("FAIL roll_hold_after_reset: roll=%0d required=1", roll);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    reset = 1'b1; enable = 1'b1; draw_req = 1'b0; shuffle = 1'b0;
    test_reset();
    test_single_draw();
    test_exhausted_skip();
    test_drain_shoe();
    test_shuffle();
    test_enable_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
